// File: rtl/run_sequencer_if.sv
// Host load/dump link and IM/DM memory ports of the run sequencer.
// master = sequencer side, slave = host plus memories.
interface run_sequencer_if #(
  parameter int IM_AW = 8,
  parameter int DM_AW = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [15:0]      load_data;
  logic             im_we;
  logic [IM_AW-1:0] im_addr;
  logic [15:0]      im_wdata;
  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [7:0]       dm_wdata;
  logic [7:0]       dm_rdata;
  logic             dump_valid;
  logic             dump_ready;
  logic [7:0]       dump_data;

  modport master (
    input  load_valid, load_data, dm_rdata, dump_ready,
    output load_ready, im_we, im_addr, im_wdata,
    output dm_we, dm_addr, dm_wdata, dump_valid, dump_data
  );

  modport slave (
    output load_valid, load_data, dm_rdata, dump_ready,
    input  load_ready, im_we, im_addr, im_wdata,
    input  dm_we, dm_addr, dm_wdata, dump_valid, dump_data
  );
endinterface

// File: rtl/run_sequencer.sv
// Job phase controller: IM load, DM load, run with watchdog, DM dump.
// Owns memory write ports during load and the DM read port during dump.
module run_sequencer #(
  parameter int IM_AW  = 8,
  parameter int DM_AW  = 8,
  parameter int WDOG_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       end_process,
  output logic [1:0] status,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  run_sequencer_if.master bus
);

  localparam int CW = (IM_AW > DM_AW) ? IM_AW : DM_AW;
  localparam logic [CW-1:0] IM_LAST = CW'((2 ** IM_AW) - 1);
  localparam logic [CW-1:0] DM_LAST = CW'((2 ** DM_AW) - 1);
  localparam logic [WDOG_W-1:0] WD_MAX = '1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DUMP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_IM,
    S_LOAD_DM,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_TX,
    S_FIN
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WDOG_W-1:0] wdog;
  logic [WDOG_W-1:0] wnext;
  logic [7:0]        dump_q;
  logic              dump_v;
  logic              in_im;
  logic              in_dm;
  logic              xfer;

  assign in_im = (state == S_LOAD_IM);
  assign in_dm = (state == S_LOAD_DM);
  assign xfer  = bus.load_valid & bus.load_ready;
  assign wnext = wdog + 1'b1;

  // Write strobes follow the handshake in the same cycle.
  assign bus.load_ready = in_im | in_dm;
  assign bus.im_we      = xfer & in_im;
  assign bus.im_addr    = cnt[IM_AW-1:0];
  assign bus.im_wdata   = bus.load_data;
  assign bus.dm_we      = xfer & in_dm;
  assign bus.dm_addr    = cnt[DM_AW-1:0];
  assign bus.dm_wdata   = bus.load_data[7:0];
  assign bus.dump_valid = dump_v;
  assign bus.dump_data  = dump_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wdog    <= '0;
      dump_q  <= '0;
      dump_v  <= 1'b0;
      status  <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_LOAD_IM;
            cnt     <= '0;
            timeout <= 1'b0;
            status  <= ST_LOAD;
            busy    <= 1'b1;
          end
        end
        S_LOAD_IM: begin
          if (xfer) begin
            if (cnt == IM_LAST) begin
              cnt   <= '0;
              state <= S_LOAD_DM;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LOAD_DM: begin
          if (xfer) begin
            if (cnt == DM_LAST) begin
              cnt    <= '0;
              wdog   <= '0;
              state  <= S_RUN;
              status <= ST_RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          wdog <= wnext;
          // A halt in the expiry cycle is a clean finish, not a timeout.
          if (end_process) begin
            state  <= S_DUMP_RD;
            status <= ST_DUMP;
          end else if (wnext == WD_MAX) begin
            timeout <= 1'b1;
            state   <= S_DUMP_RD;
            status  <= ST_DUMP;
          end
        end
        S_DUMP_RD: begin
          dump_q <= bus.dm_rdata;
          dump_v <= 1'b1;
          state  <= S_DUMP_TX;
        end
        S_DUMP_TX: begin
          if (bus.dump_ready) begin
            dump_v <= 1'b0;
            if (cnt == DM_LAST) begin
              cnt   <= '0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_DUMP_RD;
            end
          end
        end
        S_FIN: begin
          state  <= S_IDLE;
          status <= ST_IDLE;
          busy   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
